modexp_sched: RTL and testbench

MODEXP_SCHED -- requirements
Module: modexp_sched

---
 rtl/modexp_sched.sv | 157 +++++++++++++++
 tb/tb_modexp_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_sched.sv
// modexp_sched: left-to-right binary modular exponentiation scheduler.
// Issues square / multiply operations to a shared Montgomery multiplier,
// one at a time, and finally multiplies the accumulator by 1 to bring the
// result back out of the Montgomery domain.
module modexp_sched #(
    parameter int N  = 1024,
    parameter int TW = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_r,
    input  logic [N-1:0]  in_e,
    input  logic [TW-1:0] in_t,
    output logic          mm_start,
    output logic [N-1:0]  mm_a,
    output logic [N-1:0]  mm_b,
    input  logic [N-1:0]  mm_result,
    input  logic          mm_done,
    output logic [N-1:0]  result,
    output logic          done,
    output logic          busy
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] SQR   = 4'd2;
    localparam logic [3:0] SQR_W = 4'd3;
    localparam logic [3:0] MUL   = 4'd4;
    localparam logic [3:0] MUL_W = 4'd5;
    localparam logic [3:0] OUT   = 4'd6;
    localparam logic [3:0] OUT_W = 4'd7;
    localparam logic [3:0] FIN   = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  e_q, e_d;
    logic [N-1:0]  result_q, result_d;
    logic [TW-1:0] idx_q, idx_d;

    // idx counts exponent bits still to be processed; the bit being
    // processed is E[idx-1]. A shift keeps the index width independent of N.
    logic [TW-1:0] idx_dec;
    logic [N-1:0]  e_shift;
    logic          e_bit;

    assign idx_dec = idx_q - TW'(1);
    assign e_shift = e_q >> idx_dec;
    assign e_bit   = e_shift[0];

    // Next-state and datapath update; mm_done is only honoured in wait states.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_d  = state_q;
        acc_d    = acc_q;
        x_d      = x_q;
        e_d      = e_q;
        idx_d    = idx_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                acc_d   = in_r;
                x_d     = in_x;
                e_d     = in_e;
                idx_d   = in_t;
                state_d = (in_t == '0) ? OUT : SQR;
            end
            SQR:   state_d = SQR_W;
            SQR_W: begin
                if (mm_done) begin
                    acc_d = mm_result;
                    if (e_bit) begin
                        state_d = MUL;
                    end else begin
                        idx_d   = idx_dec;
                        state_d = (idx_dec != '0) ? SQR : OUT;
                    end
                end
            end
            MUL:   state_d = MUL_W;
            MUL_W: begin
                if (mm_done) begin
                    acc_d   = mm_result;
                    idx_d   = idx_dec;
                    state_d = (idx_dec != '0) ? SQR : OUT;
                end
            end
            OUT:   state_d = OUT_W;
            OUT_W: begin
                if (mm_done) begin
                    result_d = mm_result;
                    state_d  = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier operands: driven from the issue state through its wait
    // state, so they stay stable until mm_done; zero whenever idle.
    always_comb begin
        mm_start = 1'b0;
        mm_a     = '0;
        mm_b     = '0;
        case (state_q)
            SQR, SQR_W: begin
                mm_start = (state_q == SQR);
                mm_a     = acc_q;
                mm_b     = acc_q;
            end
            MUL, MUL_W: begin
                mm_start = (state_q == MUL);
                mm_a     = acc_q;
                mm_b     = x_q;
            end
            OUT, OUT_W: begin
                mm_start = (state_q == OUT);
                mm_a     = acc_q;
                mm_b     = {{(N-1){1'b0}}, 1'b1};
            end
            default: begin
                mm_start = 1'b0;
            end
        endcase
    end

    // State registers; asynchronous reset aborts any run in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            x_q      <= '0;
            e_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together.
            state_q  <= state_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            e_q      <= e_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == FIN);
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_modexp_sched.sv
// Self-checking bench for modexp_sched with a 3-cycle Montgomery multiplier
// model. The model uses R = 2, so mont(a,b) = a*b*((M+1)/2) mod M.
`timescale 1ns/1ps
module tb_modexp_sched;

    localparam int N  = 1024;
    localparam int TW = 11;

    logic          clk = 1'b0;
    logic          resetn, start;
    logic [N-1:0]  in_x, in_r, in_e;
    logic [TW-1:0] in_t;
    logic          mm_start;
    logic [N-1:0]  mm_a, mm_b, result;
    logic          done, busy;
    logic          mm_done_in;
    logic [N-1:0]  mm_result_in;

    // Multiplier model and spurious-completion injection
    logic          mm_done_m = 1'b0;
    logic [N-1:0]  mm_res_m  = '0;
    logic          spur;
    logic [N-1:0]  spur_res;
    logic [N-1:0]  m_mod;
    logic [N-1:0]  lat_a = '0, lat_b = '0;
    logic          m_out = 1'b0;
    int            m_cnt = 0;
    int            n_pulses = 0;
    int            n_viol = 0;
    logic          viol_en = 1'b1;
    logic [N-1:0]  log_a [64];
    logic [N-1:0]  log_b [64];

    int n_cmp = 0;
    int n_bad = 0;

    // Per-run bookkeeping
    int            run_base;
    int            lat;
    logic          busy_ld;
    logic [N-1:0]  big_x, big_exp;

    always #5 clk = ~clk;

    assign mm_done_in   = mm_done_m | spur;
    assign mm_result_in = spur ? spur_res : mm_res_m;

    modexp_sched #(.N(N), .TW(TW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x      (in_x),
        .in_r      (in_r),
        .in_e      (in_e),
        .in_t      (in_t),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_result (mm_result_in),
        .mm_done   (mm_done_in),
        .result    (result),
        .done      (done),
        .busy      (busy)
    );

    function automatic logic [N-1:0] modmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % {{N{1'b0}}, m_mod};
        return p[N-1:0];
    endfunction

    function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] rinv;
        rinv = (m_mod >> 1) + N'(1);
        return modmul(modmul(a, b), rinv);
    endfunction

    // Right-to-left reference exponentiation in the normal domain.
    function automatic logic [N-1:0] ref_pow(input logic [N-1:0] x, input logic [N-1:0] e, input int t);
        logic [N-1:0] r, b;
        r = modmul(N'(1), N'(1));
        b = x;
        for (int i = 0; i < t; i++) begin
            if (e[i]) r = modmul(r, b);
            b = modmul(b, b);
        end
        return r;
    endfunction

    // Multiplier model: accepts mm_start, answers three cycles later,
    // and records any operand change or re-issue while outstanding.
    always @(negedge clk) begin
        mm_done_m <= 1'b0;
        if (m_out) begin
            if (viol_en && resetn && ((mm_a !== lat_a) || (mm_b !== lat_b) || mm_start))
                n_viol <= n_viol + 1;
            if (m_cnt == 1) begin
                mm_done_m <= 1'b1;
                mm_res_m  <= mont(lat_a, lat_b);
                m_out     <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end else if (mm_start) begin
            m_out                <= 1'b1;
            m_cnt                <= 3;
            lat_a                <= mm_a;
            lat_b                <= mm_b;
            log_a[n_pulses % 64] <= mm_a;
            log_b[n_pulses % 64] <= mm_b;
            n_pulses             <= n_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Runs one exponentiation and checks latency, pulse count and result.
    task automatic run_exp(input string tag, input logic [N-1:0] x, input logic [N-1:0] r,
                           input logic [N-1:0] e, input int t,
                           input logic [N-1:0] exp_res, input int exp_n);
        logic [N-1:0] held;
        @(negedge clk);
        run_base = n_pulses;
        in_x  = x;
        in_r  = r;
        in_e  = e;
        in_t  = TW'(t);
        start = 1'b1;
        lat   = 0;
        busy_ld = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start   = 1'b0;
                busy_ld = busy;
            end
            if (lat == 2) begin
                in_x = {32{32'hdeadbeef}};
                in_r = '1;
                in_e = '0;
                in_t = '1;
            end
        end while (!done && lat < 30000);
        check({tag, "_done_seen"}, N'(done), N'(1));
        check({tag, "_busy_load"}, N'(busy_ld), N'(1));
        check({tag, "_latency"}, N'(lat), N'(2 + 4 * exp_n));
        check({tag, "_mults"}, N'(n_pulses - run_base), N'(exp_n));
        check({tag, "_result"}, result, exp_res);
        held = result;
        @(negedge clk);
        check({tag, "_done_1cyc"}, N'(done), N'(0));
        repeat (2) @(negedge clk);
        check({tag, "_result_hold"}, result, held);
    endtask

    task automatic check_pairs(input string tag, input int cnt, input int ea[8], input int eb[8]);
        for (int k = 0; k < cnt; k++) begin
            check($sformatf("%s_a%0d", tag, k), log_a[(run_base + k) % 64], N'(ea[k]));
            check($sformatf("%s_b%0d", tag, k), log_b[(run_base + k) % 64], N'(eb[k]));
        end
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        spur     = 1'b0;
        spur_res = '1;
        in_x     = '0;
        in_r     = '0;
        in_e     = '0;
        in_t     = '0;
        m_mod    = N'(13);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", N'(busy), N'(0));
        check("rst_done", N'(done), N'(0));
        check("rst_mm_start", N'(mm_start), N'(0));
        check("rst_result", result, N'(0));
        check("rst_mm_a", mm_a, N'(0));
        check("rst_mm_b", mm_b, N'(0));
        resetn = 1'b1;
        @(negedge clk);

        // M=13, x=3 (Montgomery 6), e=101b, t=3: 3^5 mod 13 = 9
        run_exp("e101", N'(6), N'(2), N'(5), 3, N'(9), 6);
        check_pairs("e101", 6, '{2, 2, 6, 5, 6, 5, 0, 0}, '{2, 6, 6, 5, 6, 1, 0, 0});

        // t=0: single conversion multiply (R,1), result 1
        run_exp("t0", N'(6), N'(2), N'(5), 0, N'(1), 1);
        check_pairs("t0", 1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0});

        // Start re-pulsed while busy and a spurious mm_done during SQR
        fork
            run_exp("spur", N'(6), N'(2), N'(5), 3, N'(9), 6);
            begin
                int w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!mm_start && w < 200);
                check("spur_sqr_seen", N'(mm_start), N'(1));
                spur  = 1'b1;
                start = 1'b1;
                @(negedge clk);
                spur  = 1'b0;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_pairs("spur", 6, '{2, 2, 6, 5, 6, 5, 0, 0}, '{2, 6, 6, 5, 6, 1, 0, 0});

        // Reset during MUL_W; the late mm_done must be ignored
        begin
            int w = 0;
            @(negedge clk);
            run_base = n_pulses;
            in_x  = N'(6);
            in_r  = N'(2);
            in_e  = N'(5);
            in_t  = TW'(3);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while ((n_pulses - run_base) < 2 && w < 200) begin
                @(negedge clk);
                w++;
            end
            check("abort_in_mul_w", mm_b, N'(6));
            viol_en = 1'b0;
            resetn  = 1'b0;
            @(negedge clk);
            check("abort_busy_rst", N'(busy), N'(0));
            resetn = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check($sformatf("abort_idle%0d", c), N'({busy, done, mm_start}), N'(0));
            end
            check("abort_result", result, N'(0));
            check("abort_mm_a", mm_a, N'(0));
            viol_en = 1'b1;
        end

        // Following run: x=5 (Montgomery 10), e=11b, t=2: 5^3 mod 13 = 8
        run_exp("after_rst", N'(10), N'(2), N'(3), 2, N'(8), 5);
        check_pairs("after_rst", 5, '{2, 2, 10, 11, 3, 0, 0, 0}, '{2, 10, 10, 10, 1, 0, 0, 0});

        // Full width: e all ones, t=N, odd 1024-bit modulus
        m_mod   = {32{32'hf1e2d3c5}};
        big_x   = {32{32'h12345678}};
        big_exp = ref_pow(big_x, '1, N);
        run_exp("full", modmul(big_x, N'(2)), N'(2), '1, N, big_exp, 2 * N + 1);

        check("operand_stability", N'(n_viol), N'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
